// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op and state encodings plus the
// operand magnitude helper used before the unsigned mul/div datapaths.
package mdu_pkg;

  // Widest XLEN the magnitude helper supports (XLEN must be below this).
  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    MDU_MUL   = 3'd0,
    MDU_MULH  = 3'd1,
    MDU_MULHU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_MOD   = 3'd4,
    MDU_DIVU  = 3'd5,
    MDU_MODU  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  // v must arrive sign-extended to MAX_XLEN; the low XLEN bits of the return
  // value are the magnitude (the most negative value maps to 2**(XLEN-1)).
  function automatic logic [MAX_XLEN-1:0] abs_val(input logic is_signed,
                                                  input logic [MAX_XLEN-1:0] v);
    return (is_signed && v[MAX_XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the execute stage and the mdu.
// master = pipeline side, slave = mdu side.
interface mdu_if #(
  parameter int XLEN = 32
);
  import mdu_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  mdu_op_t         op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, src1, src2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, src1, src2, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/mdu_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
// Latency: XLEN cycles after start; done is high during the final iteration.
// No backpressure: quo/rem hold after the last step until the next start.
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            done
);
  localparam int CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0]  dvsr;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;

  // quo doubles as the dividend shift register; its MSB feeds the remainder.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr};
  assign done    = run && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvsr <= '0;
      quo  <= '0;
      rem  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (kill) begin
      run  <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      dvsr <= divisor;
      quo  <= dividend;
      rem  <= '0;
      cnt  <= CNT_W'(XLEN - 1);
      run  <= 1'b1;
    end else if (run) begin
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle MUL/MULH/MULHU/DIV/MOD/DIVU/MODU unit; MDU_FAST_MUL_EN selects a single-cycle multiplier.
// Latency: XLEN+1 cycles to out_valid (mul 2 with MDU_FAST_MUL_EN); divide special cases and unknown ops 1.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush cancels in any state.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam int PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t      state;
  mdu_op_t         op_q;
  logic            neg_q;
  logic            negr_q;
  logic            spec_q;
  logic [XLEN-1:0] spec_res_q;
  logic [PW-1:0]   prod_q;

`ifdef MDU_FAST_MUL_EN
  logic [XLEN-1:0]      a_q;
  logic [XLEN-1:0]      b_q;
  logic                 sa_q;
  logic signed [PW-1:0] fprod;

  always_comb begin
    fprod = PW'($signed({sa_q & a_q[XLEN-1], a_q})) * PW'($signed({sa_q & b_q[XLEN-1], b_q}));
  end
`else
  logic [PW-1:0]    mcand;
  logic [XLEN-1:0]  mplier;
  logic [CNT_W-1:0] cnt;
`endif

  logic                is_mul, is_div, is_sdiv, sgn_mode, sgn1, sgn2;
  logic                div_zero, div_ovf, div_start, div_done;
  logic [MAX_XLEN-1:0] abs1_w, abs2_w;
  logic [XLEN-1:0]     mag1, mag2, quo, rem;
  logic                unused_abs_hi;

  always_comb begin
    is_mul   = bus.op inside {MDU_MUL, MDU_MULH, MDU_MULHU};
    is_div   = bus.op inside {MDU_DIV, MDU_MOD, MDU_DIVU, MDU_MODU};
    is_sdiv  = bus.op inside {MDU_DIV, MDU_MOD};
    sgn_mode = is_sdiv || (bus.op == MDU_MULH);
    sgn1     = sgn_mode && bus.src1[XLEN-1];
    sgn2     = sgn_mode && bus.src2[XLEN-1];
    abs1_w   = abs_val(sgn_mode, MAX_XLEN'($signed(bus.src1)));
    abs2_w   = abs_val(sgn_mode, MAX_XLEN'($signed(bus.src2)));
    mag1     = abs1_w[XLEN-1:0];
    mag2     = abs2_w[XLEN-1:0];
    div_zero = is_div && (bus.src2 == '0);
    div_ovf  = is_sdiv && (bus.src1 == SMIN) && (bus.src2 == ONES);
  end

  assign unused_abs_hi = ^{abs1_w[MAX_XLEN-1:XLEN], abs2_w[MAX_XLEN-1:XLEN]};
  assign div_start = (state == S_IDLE) && !bus.flush && bus.in_valid &&
                     is_div && !div_zero && !div_ovf;

  mdu_div_core #(.XLEN(XLEN)) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .kill     (bus.flush),
    .start    (div_start),
    .dividend (mag1),
    .divisor  (mag2),
    .quo      (quo),
    .rem      (rem),
    .done     (div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= MDU_MUL;
      neg_q      <= 1'b0;
      negr_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      prod_q     <= '0;
`ifdef MDU_FAST_MUL_EN
      a_q        <= '0;
      b_q        <= '0;
      sa_q       <= 1'b0;
`else
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
`endif
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          op_q   <= bus.op;
          neg_q  <= sgn1 ^ sgn2;
          negr_q <= sgn1;
          spec_q <= 1'b0;
          if (!is_mul && !is_div) begin
            spec_q     <= 1'b1;
            spec_res_q <= '0;
            state      <= S_DONE;
          end else if (div_zero) begin
            spec_q     <= 1'b1;
            spec_res_q <= (bus.op inside {MDU_DIV, MDU_DIVU}) ? ONES : bus.src1;
            state      <= S_DONE;
          end else if (div_ovf) begin
            spec_q     <= 1'b1;
            spec_res_q <= (bus.op == MDU_DIV) ? bus.src1 : '0;
            state      <= S_DONE;
          end else if (is_div) begin
            state <= S_DIV;
          end else begin
            state <= S_MUL;
`ifdef MDU_FAST_MUL_EN
            a_q  <= bus.src1;
            b_q  <= bus.src2;
            sa_q <= sgn_mode;
`else
            mcand  <= PW'(mag1);
            mplier <= mag2;
            prod_q <= '0;
            cnt    <= CNT_W'(XLEN - 1);
`endif
          end
        end
        S_MUL: begin
`ifdef MDU_FAST_MUL_EN
          prod_q <= fprod;
          state  <= S_DONE;
`else
          if (mplier[0]) prod_q <= prod_q + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - CNT_W'(1);
`endif
        end
        S_DIV:   if (div_done)      state <= S_DONE;
        S_DONE:  if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sign fix-up straight off the held magnitudes so DONE presents the final value.
  logic [PW-1:0]   mul_full;
  logic [XLEN-1:0] quo_fix, rem_fix, res;

  always_comb begin
`ifdef MDU_FAST_MUL_EN
    mul_full = prod_q;
`else
    mul_full = neg_q ? -prod_q : prod_q;
`endif
    quo_fix = neg_q  ? -quo : quo;
    rem_fix = negr_q ? -rem : rem;
    res     = '0;
    if (state == S_DONE) begin
      if (spec_q) begin
        res = spec_res_q;
      end else begin
        case (op_q)
          MDU_MUL:             res = mul_full[XLEN-1:0];
          MDU_MULH, MDU_MULHU: res = mul_full[PW-1:XLEN];
          MDU_DIV, MDU_DIVU:   res = quo_fix;
          MDU_MOD, MDU_MODU:   res = rem_fix;
          default:             res = '0;
        endcase
      end
    end
  end

  assign bus.result    = res;
  assign bus.out_valid = (state == S_DONE) && !bus.flush;
  assign bus.in_ready  = (state == S_IDLE) && !bus.flush;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: every scenario runs on an XLEN=32 and an XLEN=16 instance.
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        sel16 = 1'b0;
  mdu_op_t     op = MDU_MUL;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;

  int          w = 32;
  logic [31:0] mask = 32'hFFFF_FFFF;
  int          n_chk = 0;
  int          n_fail = 0;
  int          mul_lat;

  mdu_if #(.XLEN(32)) b32();
  mdu_if #(.XLEN(16)) b16();

  assign b32.flush     = flush;
  assign b32.in_valid  = in_valid & ~sel16;
  assign b32.op        = op;
  assign b32.src1      = src1;
  assign b32.src2      = src2;
  assign b32.out_ready = out_ready;
  assign b16.flush     = flush;
  assign b16.in_valid  = in_valid & sel16;
  assign b16.op        = op;
  assign b16.src1      = src1[15:0];
  assign b16.src2      = src2[15:0];
  assign b16.out_ready = out_ready;

  mdu #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  mdu #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  always #5 clk = ~clk;

  logic        ov, ir, bz;
  logic [31:0] res;
  assign ov  = sel16 ? b16.out_valid : b32.out_valid;
  assign ir  = sel16 ? b16.in_ready  : b32.in_ready;
  assign bz  = sel16 ? b16.busy      : b32.busy;
  assign res = sel16 ? {16'h0, b16.result} : b32.result;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  // Presents one request for a single edge; returns at the falling edge of cycle 1.
  task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; src1 = a & mask; src2 = b & mask; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (ov !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid w=%0d got %b want 0", w, ov); end
    n_chk++; if (bz !== 1'b0) begin n_fail++; $display("FAIL reset_busy w=%0d got %b want 0", w, bz); end
    n_chk++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_result w=%0d got %h want 0", w, res); end
    rst = 1'b0;
    #1;
    n_chk++; if (ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready w=%0d got %b want 1", w, ir); end
  endtask

  task automatic test_mulh;
    int lat;
    issue(MDU_MULH, 32'hFFFF_FFFF, 32'h2);
    wait_valid(lat);
    n_chk++; if (lat != mul_lat) begin n_fail++; $display("FAIL mulh_latency w=%0d got %0d want %0d", w, lat, mul_lat); end
    n_chk++; if (res !== mask) begin n_fail++; $display("FAIL mulh_result w=%0d got %h want %h", w, res, mask); end
    issue(MDU_MUL, 32'h7, 32'h9);
    wait_valid(lat);
    n_chk++; if (res !== 32'd63) begin n_fail++; $display("FAIL mul_result w=%0d got %h want 3f", w, res); end
  endtask

  task automatic test_div;
    int lat;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_valid(lat);
    n_chk++; if (lat != w + 1) begin n_fail++; $display("FAIL div_latency w=%0d got %0d want %0d", w, lat, w + 1); end
    n_chk++; if (res !== (32'hFFFF_FFFD & mask)) begin n_fail++; $display("FAIL div_result w=%0d got %h want %h", w, res, 32'hFFFF_FFFD & mask); end
    issue(MDU_MOD, 32'hFFFF_FFF9, 32'h2);
    wait_valid(lat);
    n_chk++; if (res !== mask) begin n_fail++; $display("FAIL mod_result w=%0d got %h want %h", w, res, mask); end
    issue(MDU_MODU, 32'hFFFF_FFF9, 32'h2);
    wait_valid(lat);
    n_chk++; if (res !== 32'h1) begin n_fail++; $display("FAIL modu_result w=%0d got %h want 1", w, res); end
    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_valid(lat);
    n_chk++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_result w=%0d got %h want e", w, res); end
  endtask

  task automatic test_div_zero;
    int lat;
    issue(MDU_DIVU, 32'h1234, 32'h0);
    wait_valid(lat);
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL divu0_latency w=%0d got %0d want 1", w, lat); end
    n_chk++; if (res !== mask) begin n_fail++; $display("FAIL divu0_result w=%0d got %h want %h", w, res, mask); end
    issue(MDU_MODU, 32'h1234, 32'h0);
    wait_valid(lat);
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL modu0_latency w=%0d got %0d want 1", w, lat); end
    n_chk++; if (res !== 32'h1234) begin n_fail++; $display("FAIL modu0_result w=%0d got %h want 1234", w, res); end
  endtask

  task automatic test_overflow;
    int lat;
    logic [31:0] smin;
    smin = 32'h1 << (w - 1);
    issue(MDU_DIV, smin, 32'hFFFF_FFFF);
    wait_valid(lat);
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL ovf_div_latency w=%0d got %0d want 1", w, lat); end
    n_chk++; if (res !== smin) begin n_fail++; $display("FAIL ovf_div_result w=%0d got %h want %h", w, res, smin); end
    issue(MDU_MOD, smin, 32'hFFFF_FFFF);
    wait_valid(lat);
    n_chk++; if (res !== 32'h0) begin n_fail++; $display("FAIL ovf_mod_result w=%0d got %h want 0", w, res); end
  endtask

  task automatic test_unknown;
    int lat;
    issue(mdu_op_t'(3'd7), 32'h55, 32'h3);
    wait_valid(lat);
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL unknown_latency w=%0d got %0d want 1", w, lat); end
    n_chk++; if (res !== 32'h0) begin n_fail++; $display("FAIL unknown_result w=%0d got %h want 0", w, res); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    op = MDU_DIVU; src1 = 32'h5; src2 = 32'h0; in_valid = 1'b1;
    @(negedge clk);
    n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid w=%0d got %b want 1", w, ov); end
    n_chk++; if (ir !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done w=%0d got %b want 0", w, ir); end
    @(negedge clk);
    n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid w=%0d got %b want 0", w, ov); end
    @(negedge clk);
    n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid w=%0d got %b want 1", w, ov); end
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL b2b_drain w=%0d got %b want 0", w, ov); end
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL bp_valid w=%0d cyc=%0d got %b want 1", w, i, ov); end
      n_chk++; if (res !== 32'd14) begin n_fail++; $display("FAIL bp_result w=%0d cyc=%0d got %h want e", w, i, res); end
      n_chk++; if (ir !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready w=%0d cyc=%0d got %b want 0", w, i, ir); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid w=%0d got %b want 0", w, ov); end
    n_chk++; if (bz !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy w=%0d got %b want 0", w, bz); end
  endtask

  task automatic test_flush;
    int lat;
    int seen;
    issue(MDU_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    n_chk++; if (bz !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before w=%0d got %b want 1", w, bz); end
    n_chk++; if (ir !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready w=%0d got %b want 0", w, ir); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_chk++; if (bz !== 1'b0) begin n_fail++; $display("FAIL flush_idle w=%0d got %b want 0", w, bz); end
    n_chk++; if (ir !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after w=%0d got %b want 1", w, ir); end
    seen = 0;
    repeat (w + 4) begin
      @(negedge clk);
      if (ov === 1'b1) seen++;
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_result w=%0d got %0d valid cycles want 0", w, seen); end
    // A request presented during flush in IDLE must be dropped.
    flush = 1'b1; in_valid = 1'b1; op = MDU_DIVU; src1 = 32'h9; src2 = 32'h0;
    #1;
    n_chk++; if (ir !== 1'b0) begin n_fail++; $display("FAIL flush_idle_ready w=%0d got %b want 0", w, ir); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (bz !== 1'b0) begin n_fail++; $display("FAIL flush_drop_req w=%0d got %b want 0", w, bz); end
    issue(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(lat);
    n_chk++; if (lat != mul_lat) begin n_fail++; $display("FAIL mulhu_latency w=%0d got %0d want %0d", w, lat, mul_lat); end
    n_chk++; if (res !== (32'hFFFF_FFFE & mask)) begin n_fail++; $display("FAIL mulhu_result w=%0d got %h want %h", w, res, 32'hFFFF_FFFE & mask); end
  endtask

  task automatic test_async_reset;
    int lat;
    out_ready = 1'b0;
    issue(MDU_MUL, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    n_chk++; if (bz !== 1'b1) begin n_fail++; $display("FAIL arst_busy_before w=%0d got %b want 1", w, bz); end
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (bz !== 1'b0) begin n_fail++; $display("FAIL arst_busy_drop w=%0d got %b want 0", w, bz); end
    n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL arst_valid_drop w=%0d got %b want 0", w, ov); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    n_chk++; if (ir !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready w=%0d got %b want 1", w, ir); end
    n_chk++; if (res !== 32'h0) begin n_fail++; $display("FAIL arst_result w=%0d got %h want 0", w, res); end
    issue(MDU_MUL, 32'd7, 32'd9);
    wait_valid(lat);
    n_chk++; if (lat != mul_lat) begin n_fail++; $display("FAIL arst_mul_latency w=%0d got %0d want %0d", w, lat, mul_lat); end
    n_chk++; if (res !== 32'd63) begin n_fail++; $display("FAIL arst_mul_result w=%0d got %h want 3f", w, res); end
  endtask

  task automatic run_all;
`ifdef MDU_FAST_MUL_EN
    mul_lat = 2;
`else
    mul_lat = w + 1;
`endif
    test_reset;
    test_mulh;
    test_div;
    test_div_zero;
    test_overflow;
    test_unknown;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_async_reset;
  endtask

  initial begin
    sel16 = 1'b0; w = 32; mask = 32'hFFFF_FFFF;
    run_all;
    @(negedge clk);
    sel16 = 1'b1; w = 16; mask = 32'h0000_FFFF;
    run_all;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit; implements the MUL/MULH/MULHU/DIV/MOD/DIVU/MODU ops that the single-cycle ALU leaves empty.
- Sits beside the ALU in execute; the pipeline stalls on in_ready/out_valid.
- Width-parametrised, valid/ready handshake on both sides, flush support, divide special-case fast path.

Parameters:
XLEN, 32, operand/result width (>=8, even)
CNT_W, $clog2(XLEN+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous cancel of in-flight op
in_valid  in  1  request valid
in_ready  out  1  unit can accept (state==IDLE)
op  in  MduOp(3)  operation select
src1  in  XLEN  operand A (dividend/multiplicand)
src2  in  XLEN  operand B (divisor/multiplier)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  result
busy  out  1  state!=IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, in_ready=1 after release, busy=0, result=0, counter=0.
- States: IDLE, MUL, DIV, DONE.
- Accept: in_valid && in_ready at edge E0. Operands, op and sign flags are latched.
  - Mul ops -> MUL. Div ops -> DIV.
  - Exception: divisor==0 or signed overflow -> DONE directly.
- MUL (iterative shift-add on magnitudes, 2*XLEN product):
  - XLEN cycles, counter XLEN-1 down to 0, then DONE.
  - out_valid first high in cycle XLEN+1 after accept.
- DIV (restoring radix-2 on magnitudes):
  - XLEN cycles, then DONE; same latency as MUL.
  - Special cases: out_valid in cycle 1 after accept.
- Op semantics:
  - MUL: low XLEN bits of the product.
  - MULH: high XLEN bits, signed x signed.
  - MULHU: high XLEN bits, unsigned.
  - DIV/MOD: signed, quotient truncated toward zero, remainder takes the dividend's sign.
  - DIVU/MODU: unsigned.
- Sign fix-up (negate quotient/remainder per latched flags) is combinational from the DONE registers; no extra cycle.
- Divide by zero: quotient = all ones; remainder = src1.
- Signed overflow (src1 = 100..0, src2 = all ones, DIV/MOD): quotient = src1, remainder = 0.
- DONE: out_valid = !flush. Result is held stable while out_valid && !out_ready. Goes to IDLE on out_ready.
- in_ready is 0 in DONE; no same-cycle back-to-back accept. Minimum issue interval is 2 cycles (fast path).
- flush (highest priority, any state):
  - Next state is IDLE; out_valid is forced 0 combinationally the same cycle.
  - in_valid in a flush cycle is not accepted; in_ready = (state==IDLE) && !flush.
- Reset mid-operation aborts immediately; no partial result is ever presented.
- Unknown op encoding: treated as MUL, result 0 via DONE in cycle 1.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: MUL state lasts 1 cycle. The full signed/unsigned product is formed with one (XLEN+1)x(XLEN+1) signed multiply and registered. Mul latency is 2 cycles (out_valid in cycle 2 after accept); divide is unchanged.
- Undefined: iterative shift-add multiply, XLEN-cycle latency as above.
- Results are bit-identical either way.

Decomposition:
- cpuDefine package:
  - MduOp enum: MDU_MUL, MDU_MULH, MDU_MULHU, MDU_DIV, MDU_MOD, MDU_DIVU, MDU_MODU.
  - MduState enum.
  - Helper function abs_val(signed flag, XLEN value).
- One sub-module, div_core: iterative restoring divider holding the partial remainder/quotient shift registers and the counter.
  - start/done handshake.
  - Unsigned magnitudes only.
  - mdu owns sign handling, special cases and the output handshake.

Test Plan:
- MULH, src1=0xFFFFFFFF (-1), src2=0x00000002, XLEN=32 -> result 0xFFFFFFFF; out_valid exactly 33 cycles after accept (2 cycles with MDU_FAST_MUL_EN).
- DIV, src1=-7 (0xFFFFFFF9), src2=2 -> 0xFFFFFFFD (-3). MOD with the same operands -> 0xFFFFFFFF (-1). MODU with the same operands -> 0x00000001.
- DIVU, src2=0, src1=0x1234 -> 0xFFFFFFFF; MODU same operands -> 0x00001234; both with out_valid 1 cycle after accept.
- DIV, src1=0x80000000, src2=0xFFFFFFFF -> 0x80000000; MOD same operands -> 0; fast-path latency 1.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable; in_ready=0 throughout.
  - Assert flush at cycle 10 of a DIV -> IDLE next cycle, no out_valid.
  - A new MULHU 0xFFFFFFFF x 0xFFFFFFFF then returns 0xFFFFFFFE.
- Async reset asserted mid-MUL between clock edges -> out_valid/busy drop immediately and in_ready=1 after release. Repeat all scenarios with XLEN=16.
